reg_file_scb: RTL and testbench
===============================

# reg_file_scb

Parametrised multi-read-port register file with an integrated per-register busy scoreboard and writeback bypass. It serves as the integer register file of the pipelined core. It replaces the fixed 32x32 two-read-port file and adds three capabilities: asynchronous reset of contents, tracking of pending writes so decode can detect RAW hazards, and same-cycle forwarding of writeback data to the read ports.

## Interface
Parameters:
- XLEN, 32, register width in bits.
- NREGS, 32, number of architectural registers; must be a power of two, minimum 2.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as zero and is never written or marked busy.

Derived: AW = $clog2(NREGS), CW = $clog2(NREGS+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational; port i occupies bits [i*XLEN +: XLEN].
- rd_ready  out  NRD  port i data is architecturally current (not pending, or bypassed).
- iss_valid  in  1  decode requests to mark iss_addr as pending-write.
- iss_addr  in  AW  destination register of the issuing instruction.
- iss_ready  out  1  issue can be accepted this cycle.
- wb_valid  in  1  writeback strobe.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback value.
- busy_cnt  out  CW  registered count of currently busy registers.

## Operation
- State: rf[NREGS] of XLEN bits, busy[NREGS] bits, busy_cnt.
- Reset (rst=1, asynchronous): all rf entries = 0, all busy = 0, busy_cnt = 0. This holds for the whole time rst is high. Any issue or writeback in progress is discarded.
- Writeback: on a clock edge with wb_valid=1, rf[wb_addr] <= wb_data and busy[wb_addr] <= 0.
  - Ignored entirely when ZERO_REG=1 and wb_addr=0.
  - A writeback to a non-busy register is legal and still writes.
- Issue handshake:
  - iss_ready = !busy[iss_addr] || (wb_valid && wb_addr==iss_addr) || (ZERO_REG && iss_addr==0).
  - On an edge with iss_valid && iss_ready, busy[iss_addr] <= 1, except for register 0 when ZERO_REG=1 (accepted, no state change).
  - With iss_valid && !iss_ready, nothing changes; decode holds and retries.
- Simultaneous issue and writeback to the same address: data is written and busy ends at 1 (the new issue wins).
- Read port i (purely combinational):
  - If ZERO_REG and rd_addr_i==0: data 0, ready 1.
  - Else if wb_valid && wb_addr==rd_addr_i: data wb_data, ready 1 (bypass).
  - Else: data rf[rd_addr_i], ready !busy[rd_addr_i].
- busy_cnt next = busy_cnt + (set this edge) − (cleared this edge).
  - A set and a clear on the same register in the same edge net to 0.
  - A set on one register and a clear on another in the same edge also net to 0.
  - busy_cnt never exceeds NREGS − ZERO_REG.

## Timing
- Read: zero-cycle latency (address to data and ready in the same cycle, including bypass).
- Issue: busy is visible on rd_ready in the cycle after acceptance.
- Writeback: data is visible through bypass in the same cycle and from rf on the following cycle. busy clears on the following cycle.
- busy_cnt updates one cycle after the causing edge, consistent with the busy bits.
- Reset release: the first edge with rst=0 may accept an issue or writeback.
- No combinational path from iss_valid to any output. There is a combinational path from wb_* to rd_data, rd_ready and iss_ready.

## Structure
- Shared package reg_file_pkg:
  - XLEN default.
  - Register-index typedef of AW bits.
  - REG_ZERO constant (index 0).
  - A typedef for the writeback bundle (valid, addr, data), reused by the writeback stage.
- Sub-module reg_scoreboard holds busy[NREGS] and busy_cnt. Its inputs are the issue and writeback strobes with their addresses. Its outputs are the busy vector and the count.
- The top level holds rf, the read muxes, the bypass compare and iss_ready.

## Test plan
- Reset mid-operation: assert rst while busy_cnt=3 → all rd_data=0, all rd_ready=1, busy_cnt=0 immediately.
- Issue x5 with wb_valid=0 → next cycle rd_addr=5 gives rd_ready=0 and busy_cnt=1. Then wb x5=0xDEADBEEF → same cycle rd_data=0xDEADBEEF with ready=1; next cycle busy_cnt=0 and rf read returns 0xDEADBEEF.
- x0 handling (ZERO_REG=1): wb x0=0x1234 and issue x0 → rd_data=0, rd_ready=1, busy_cnt stays 0, iss_ready=1.
- Same-cycle collisions:
  - Issue x7 while it is busy → iss_ready=0 and no change.
  - Issue x7 and wb x7=0x55 in the same cycle → accepted; afterwards busy[7]=1, rf[7]=0x55, busy_cnt unchanged.
- Count saturation: issue every register 1..31 → busy_cnt=31 and all iss_ready=0 for busy targets. Then wb all → busy_cnt=0.
- Parameter sweep NREGS=16, XLEN=64, NRD=3: three read ports on distinct, equal and bypassed addresses return the correct 64-bit values simultaneously.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the integer register file and the stages around it.
// The writeback bundle lets the writeback stage carry valid/addr/data as one value.
package reg_file_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT = $clog2(NREGS_DEFAULT);
    localparam int REG_ZERO = 0;

    typedef logic [AW_DEFAULT-1:0] reg_idx_t;

    typedef struct packed {
        logic                    valid;
        reg_idx_t                addr;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_bundle_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracking: busy bits plus a running count of busy registers.
// The set and clear strobes are pre-qualified by the register file (no register-0 traffic).
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_valid,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_valid,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_cnt
);
    logic [NREGS-1:0] busy_reg, busy_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             inc, dec;

    // A set on the register being cleared wins, so that register stays counted.
    always_comb begin
        busy_next = busy_reg;
        if (clr_valid) busy_next[clr_addr] = 1'b0;
        if (set_valid) busy_next[set_addr] = 1'b1;
        inc      = set_valid && !busy_reg[set_addr];
        dec      = clr_valid && busy_reg[clr_addr] && !(set_valid && set_addr == clr_addr);
        cnt_next = cnt_reg + CW'(inc) - CW'(dec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign busy     = busy_reg;
    assign busy_cnt = cnt_reg;
endmodule

// File: rtl/reg_file_scb.sv
// Multi-read-port integer register file with pending-write scoreboard and writeback bypass.
// Reads are combinational; writeback data is forwarded to readers in the cycle it arrives.
module reg_file_scb
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_ready,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    output logic              iss_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic [CW-1:0]     busy_cnt
);
    logic [XLEN-1:0]  rf [NREGS];
    logic [NREGS-1:0] busy;
    logic             wb_act, wb_zero, wr_en, iss_zero, set_valid;

    // Bypass is suppressed while reset is held so every port reads the cleared state.
    assign wb_act    = wb_valid && !rst;
    assign wb_zero   = (ZERO_REG != 0) && (wb_addr == AW'(REG_ZERO));
    assign iss_zero  = (ZERO_REG != 0) && (iss_addr == AW'(REG_ZERO));
    assign wr_en     = wb_act && !wb_zero;
    assign iss_ready = !busy[iss_addr] || (wb_act && wb_addr == iss_addr) || iss_zero;
    assign set_valid = iss_valid && iss_ready && !iss_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[wb_addr] <= wb_data;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (CW)
    ) u_scb (
        .clk       (clk),
        .rst       (rst),
        .set_valid (set_valid),
        .set_addr  (iss_addr),
        .clr_valid (wr_en),
        .clr_addr  (wb_addr),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          hit_zero, hit_wb;
            assign addr     = rd_addr[gi*AW +: AW];
            assign hit_zero = (ZERO_REG != 0) && (addr == AW'(REG_ZERO));
            assign hit_wb   = wb_act && (wb_addr == addr);
            assign rd_data[gi*XLEN +: XLEN] = hit_zero ? '0 : (hit_wb ? wb_data : rf[addr]);
            assign rd_ready[gi] = hit_zero || hit_wb || !busy[addr];
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_scb.sv
// Self-checking bench for reg_file_scb: vector table with a busy_cnt scoreboard queue,
// plus reset, saturation and wide-parameter sequences.
module tb_reg_file_scb;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  busy_cnt;

    logic [11:0]  rd_addr2;
    logic [191:0] rd_data2;
    logic [2:0]   rd_ready2;
    logic         iss_valid2;
    logic [3:0]   iss_addr2;
    logic         iss_ready2;
    logic         wb_valid2;
    logic [3:0]   wb_addr2;
    logic [63:0]  wb_data2;
    logic [4:0]   busy_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_file_scb u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .busy_cnt(busy_cnt)
    );

    reg_file_scb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(1)) u_dut2 (
        .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_ready(rd_ready2),
        .iss_valid(iss_valid2), .iss_addr(iss_addr2), .iss_ready(iss_ready2),
        .wb_valid(wb_valid2), .wb_addr(wb_addr2), .wb_data(wb_data2), .busy_cnt(busy_cnt2)
    );

    typedef struct {
        logic        iv;
        logic [4:0]  ia;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0, r1;
        logic        e_ir;
        logic [31:0] e_d0;
        logic        e_r0;
        logic [31:0] e_d1;
        logic        e_r1;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t       vecs[15];
    logic [5:0] cnt_q[$];

    function automatic vec_t mk(logic iv, logic [4:0] ia, logic wv, logic [4:0] wa,
                                logic [31:0] wd, logic [4:0] r0, logic [4:0] r1,
                                logic e_ir, logic [31:0] e_d0, logic e_r0,
                                logic [31:0] e_d1, logic e_r1, logic [5:0] e_cnt);
        vec_t v;
        v.iv = iv; v.ia = ia; v.wv = wv; v.wa = wa; v.wd = wd; v.r0 = r0; v.r1 = r1;
        v.e_ir = e_ir; v.e_d0 = e_d0; v.e_r0 = e_r0; v.e_d1 = e_d1; v.e_r1 = e_r1;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_addr = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_cnt;

        //   iv ia   wv wa  wd            r0 r1  ir d0            r0 d1            r1 cnt
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,        5, 0, 1, 32'h0,        1, 32'h0,        1, 0);
        vecs[1]  = mk(1, 5, 0, 0, 32'h0,        5, 0, 1, 32'h0,        1, 32'h0,        1, 1);
        vecs[2]  = mk(0, 5, 0, 0, 32'h0,        5, 0, 0, 32'h0,        0, 32'h0,        1, 1);
        vecs[3]  = mk(0, 5, 1, 5, 32'hDEADBEEF, 5, 5, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0);
        vecs[4]  = mk(0, 5, 0, 0, 32'h0,        5, 0, 1, 32'hDEADBEEF, 1, 32'h0,        1, 0);
        vecs[5]  = mk(1, 0, 1, 0, 32'h1234,     0, 0, 1, 32'h0,        1, 32'h0,        1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,        0, 5, 1, 32'h0,        1, 32'hDEADBEEF, 1, 0);
        vecs[7]  = mk(1, 7, 0, 0, 32'h0,        7, 5, 1, 32'h0,        1, 32'hDEADBEEF, 1, 1);
        vecs[8]  = mk(1, 7, 0, 0, 32'h0,        7, 0, 0, 32'h0,        0, 32'h0,        1, 1);
        vecs[9]  = mk(0, 7, 0, 0, 32'h0,        7, 0, 0, 32'h0,        0, 32'h0,        1, 1);
        vecs[10] = mk(1, 7, 1, 7, 32'h55,       7, 0, 1, 32'h55,       1, 32'h0,        1, 1);
        vecs[11] = mk(0, 7, 0, 0, 32'h0,        7, 0, 0, 32'h55,       0, 32'h0,        1, 1);
        vecs[12] = mk(1, 3, 1, 9, 32'hAAAA,     9, 3, 1, 32'hAAAA,     1, 32'h0,        1, 2);
        vecs[13] = mk(1, 4, 1, 7, 32'h77,       7, 9, 1, 32'h77,       1, 32'hAAAA,     1, 2);
        vecs[14] = mk(0, 3, 0, 0, 32'h0,        3, 4, 0, 32'h0,        0, 32'h0,        0, 2);

        rst = 1'b1;
        idle_inputs();
        rd_addr = {5'd9, 5'd5};
        iss_valid2 = 1'b0; iss_addr2 = '0; wb_valid2 = 1'b0; wb_addr2 = '0; wb_data2 = '0;
        rd_addr2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy_cnt", busy_cnt, 0);
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_rd_ready", rd_ready, 2'b11);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            iss_valid = vecs[i].iv; iss_addr = vecs[i].ia;
            wb_valid = vecs[i].wv; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
            rd_addr = {vecs[i].r1, vecs[i].r0};
            #1;
            $display("[TB] vec %0d iss=%0b/x%0d wb=%0b/x%0d=%0h rd=x%0d,x%0d -> ir=%0b d0=%0h d1=%0h rdy=%b",
                     i, vecs[i].iv, vecs[i].ia, vecs[i].wv, vecs[i].wa, vecs[i].wd,
                     vecs[i].r0, vecs[i].r1, iss_ready, rd_data[31:0], rd_data[63:32], rd_ready);
            chk($sformatf("vec%0d_iss_ready", i), iss_ready, vecs[i].e_ir);
            chk($sformatf("vec%0d_rd0_data", i), rd_data[31:0], vecs[i].e_d0);
            chk($sformatf("vec%0d_rd0_ready", i), rd_ready[0], vecs[i].e_r0);
            chk($sformatf("vec%0d_rd1_data", i), rd_data[63:32], vecs[i].e_d1);
            chk($sformatf("vec%0d_rd1_ready", i), rd_ready[1], vecs[i].e_r1);
            cnt_q.push_back(vecs[i].e_cnt);
            @(posedge clk);
            #1;
            exp_cnt = cnt_q.pop_front();
            chk($sformatf("vec%0d_busy_cnt", i), busy_cnt, exp_cnt);
        end

        // Reset mid-operation with three registers busy.
        @(negedge clk);
        idle_inputs();
        iss_valid = 1'b1; iss_addr = 5'd10;
        @(posedge clk);
        #1;
        chk("pre_reset_busy_cnt", busy_cnt, 3);
        @(negedge clk);
        idle_inputs();
        rd_addr = {5'd7, 5'd9};
        #2 rst = 1'b1;
        #1;
        $display("[TB] async reset asserted: busy_cnt=%0d rd_data=%0h rd_ready=%b", busy_cnt, rd_data, rd_ready);
        chk("async_reset_busy_cnt", busy_cnt, 0);
        chk("async_reset_rd_data", rd_data, 64'h0);
        rd_addr = {5'd4, 5'd3};
        #1;
        chk("async_reset_rd_ready", rd_ready, 2'b11);
        @(negedge clk);
        rst = 1'b0;
        rd_addr = {5'd7, 5'd9};
        #1;
        chk("post_reset_rf_cleared", rd_data, 64'h0);

        // Saturation: mark every non-zero register busy, then write all back.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            iss_valid = 1'b1; iss_addr = 5'(a);
            #1;
            chk($sformatf("sat_issue_ready_x%0d", a), iss_ready, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        $display("[TB] saturation: busy_cnt=%0d", busy_cnt);
        chk("sat_busy_cnt", busy_cnt, 31);
        for (int a = 1; a < 32; a++) begin
            iss_addr = 5'(a);
            #1;
            chk($sformatf("sat_busy_iss_ready_x%0d", a), iss_ready, 1'b0);
        end
        iss_addr = 5'd0;
        rd_addr = {5'd31, 5'd1};
        #1;
        chk("sat_x0_iss_ready", iss_ready, 1'b1);
        chk("sat_rd_ready", rd_ready, 2'b00);
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            wb_valid = 1'b1; wb_addr = 5'(a); wb_data = 32'(a * 3);
            @(posedge clk);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        $display("[TB] drain: busy_cnt=%0d rd_data=%0h", busy_cnt, rd_data);
        chk("drain_busy_cnt", busy_cnt, 0);
        chk("drain_rd_data", rd_data, {32'd93, 32'd3});
        chk("drain_rd_ready", rd_ready, 2'b11);

        // Wide configuration: three ports, 64-bit data, 16 registers.
        @(negedge clk);
        wb_valid2 = 1'b1; wb_addr2 = 4'd3; wb_data2 = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        wb_addr2 = 4'd9; wb_data2 = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        wb_addr2 = 4'd12; wb_data2 = 64'hFEDC_BA98_7654_3210;
        rd_addr2 = {4'd12, 4'd3, 4'd3};
        #1;
        $display("[TB] wide bypass: rd_data2=%0h rd_ready2=%b", rd_data2, rd_ready2);
        chk("wide_equal_port0", rd_data2[63:0], 64'h0123_4567_89AB_CDEF);
        chk("wide_equal_port1", rd_data2[127:64], 64'h0123_4567_89AB_CDEF);
        chk("wide_bypass_port2", rd_data2[191:128], 64'hFEDC_BA98_7654_3210);
        chk("wide_ready", rd_ready2, 3'b111);
        @(negedge clk);
        wb_valid2 = 1'b0;
        rd_addr2 = {4'd12, 4'd9, 4'd3};
        #1;
        $display("[TB] wide distinct: rd_data2=%0h busy_cnt2=%0d", rd_data2, busy_cnt2);
        chk("wide_distinct_port0", rd_data2[63:0], 64'h0123_4567_89AB_CDEF);
        chk("wide_distinct_port1", rd_data2[127:64], 64'hCAFE_F00D_1234_5678);
        chk("wide_rf_port2", rd_data2[191:128], 64'hFEDC_BA98_7654_3210);
        chk("wide_busy_cnt", busy_cnt2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
